// File: rtl/kgp_ctrl_pkg.sv
`default_nettype none
// kgp_ctrl_pkg: shared opcode, branch-condition, field-position and state definitions
// for the KGP_RISC execution controller.
package kgp_ctrl_pkg;

  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_IMM   = 3'd1;
  localparam logic [2:0] OP_LD    = 3'd2;
  localparam logic [2:0] OP_ST    = 3'd3;
  localparam logic [2:0] OP_BR    = 3'd4;
  localparam logic [2:0] OP_JMP   = 3'd5;
  localparam logic [2:0] OP_ILL   = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  localparam logic [3:0] BR_ALWAYS = 4'd0;
  localparam logic [3:0] BR_EQZ    = 4'd1;
  localparam logic [3:0] BR_NEZ    = 4'd2;
  localparam logic [3:0] BR_LTZ    = 4'd3;

  // ALU opcode whose operand-select reads zero; used whenever the ALU is unused.
  localparam logic [2:0] ALU_OP_IDLE = 3'd2;

  localparam int OPC_LSB   = 29;
  localparam int RS_LSB    = 24;
  localparam int RT_LSB    = 19;
  localparam int SHAMT_LSB = 14;
  localparam int FCODE_LSB = 0;
  localparam int IMMT_LSB  = 0;
  localparam int IMMT_W    = 22;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_e;

  function automatic logic [31:0] sext_immt(input logic [IMMT_W-1:0] v);
    return {{(32-IMMT_W){v[IMMT_W-1]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/kgp_branch_eval.sv
`default_nettype none
// kgp_branch_eval: combinational branch-condition evaluation on the rs operand.
module kgp_branch_eval
  import kgp_ctrl_pkg::*;
(
  input  logic [3:0]  fcode_i,
  input  logic [31:0] rs_data_i,
  output logic        taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (fcode_i)
      BR_ALWAYS: taken_o = 1'b1;
      BR_EQZ:    taken_o = (rs_data_i == 32'd0);
      BR_NEZ:    taken_o = (rs_data_i != 32'd0);
      BR_LTZ:    taken_o = rs_data_i[31];
      default:   taken_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/kgp_exec_controller.sv
`default_nettype none
// kgp_exec_controller: multi-cycle fetch/decode/execute/memory/write-back sequencer
// for KGP_RISC; sole owner of the PC.
module kgp_exec_controller
  import kgp_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [2:0]  alu_opcode,
  output logic [3:0]  alu_fcode,
  output logic [4:0]  alu_shamt,
  output logic [21:0] alu_immt,
  input  logic [31:0] alu_result,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic        busy,
  output logic        halted,
  output logic        trap,
  output logic [31:0] retired
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_q, ld_q, retired_q;
  logic        taken_q;
  logic [2:0]  op_q, alu_op_q;
  logic [3:0]  fcode_q;
  logic [4:0]  rs_q, rt_q, shamt_q;
  logic [21:0] immt_q;

  logic [2:0]  dec_op, dec_alu_op;
  logic [3:0]  dec_fcode;
  logic        br_taken;
  logic [31:0] pc_plus4, br_off, next_pc;

  assign dec_op = imem_rdata[OPC_LSB +: 3];

  // Loads/stores borrow the immediate-add ALU path to form rs + sext(immt).
  always_comb begin
    dec_alu_op = ALU_OP_IDLE;
    dec_fcode  = imem_rdata[FCODE_LSB +: 4];
    case (dec_op)
      OP_RTYPE, OP_IMM: dec_alu_op = dec_op;
      OP_LD, OP_ST: begin
        dec_alu_op = OP_IMM;
        dec_fcode  = 4'd0;
      end
      default: dec_alu_op = ALU_OP_IDLE;
    endcase
  end

  kgp_branch_eval u_branch_eval (
    .fcode_i   (fcode_q),
    .rs_data_i (rs_data),
    .taken_o   (br_taken)
  );

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = sext_immt(immt_q) << 2;

  always_comb begin
    next_pc = pc_plus4;
    if (op_q == OP_JMP) begin
      next_pc = {rs_data[31:2], 2'b00};
    end else if (op_q == OP_BR && taken_q) begin
      next_pc = pc_plus4 + br_off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      alu_q     <= 32'd0;
      ld_q      <= 32'd0;
      retired_q <= 32'd0;
      taken_q   <= 1'b0;
      op_q      <= OP_RTYPE;
      alu_op_q  <= ALU_OP_IDLE;
      fcode_q   <= 4'd0;
      rs_q      <= 5'd0;
      rt_q      <= 5'd0;
      shamt_q   <= 5'd0;
      immt_q    <= 22'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == ST_FETCH && imem_ack) begin
        op_q     <= dec_op;
        alu_op_q <= dec_alu_op;
        fcode_q  <= dec_fcode;
        rs_q     <= imem_rdata[RS_LSB +: 5];
        rt_q     <= imem_rdata[RT_LSB +: 5];
        shamt_q  <= imem_rdata[SHAMT_LSB +: 5];
        immt_q   <= imem_rdata[IMMT_LSB +: IMMT_W];
      end
      if (state_q == ST_EXEC) begin
        alu_q   <= alu_result;
        taken_q <= br_taken;
      end
      if (state_q == ST_MEM && dmem_ack) begin
        ld_q <= dmem_rdata;
      end
      if (state_q == ST_WB) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    busy     = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (imem_ack) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        busy = 1'b1;
        if (op_q == OP_ILL)       state_d = ST_TRAP;
        else if (op_q == OP_HALT) state_d = ST_HALT;
        else                      state_d = ST_EXEC;
      end
      ST_EXEC: begin
        busy    = 1'b1;
        state_d = (op_q == OP_LD || op_q == OP_ST) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        busy     = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_ST);
        if (dmem_ack) state_d = ST_WB;
      end
      ST_WB: begin
        busy     = 1'b1;
        rf_we    = (op_q == OP_RTYPE || op_q == OP_IMM || op_q == OP_LD);
        rf_waddr = (op_q == OP_LD) ? rt_q : rs_q;
        rf_wdata = (op_q == OP_LD) ? ld_q : alu_q;
        pc_d     = next_pc;
        state_d  = ST_FETCH;
      end
      default: state_d = state_q;
    endcase
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = alu_q;
  assign dmem_wdata = rt_data;
  assign rs_addr    = rs_q;
  assign rt_addr    = rt_q;
  assign alu_opcode = alu_op_q;
  assign alu_fcode  = fcode_q;
  assign alu_shamt  = shamt_q;
  assign alu_immt   = immt_q;
  assign pc         = pc_q;
  assign retired    = retired_q;
  assign halted     = (state_q == ST_HALT);
  assign trap       = (state_q == ST_TRAP);

endmodule
`default_nettype wire

// File: tb/tb_kgp_exec_controller.sv
`default_nettype none
// tb_kgp_exec_controller: directed table-driven bench with a small register-file,
// ALU and memory-responder environment around the controller.
module tb_kgp_exec_controller;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'd0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'd0;
  logic [4:0]  rs_addr, rt_addr, rf_waddr, alu_shamt;
  logic [31:0] rs_data, rt_data, alu_result, rf_wdata, pc, retired;
  logic [2:0]  alu_opcode;
  logic [3:0]  alu_fcode;
  logic [21:0] alu_immt;
  logic        rf_we, busy, halted, trap;

  logic [31:0] regs [32] = '{default: 32'd0};
  logic        tb_wr = 1'b0;
  logic [4:0]  tb_idx = 5'd0;
  logic [31:0] tb_val = 32'd0;

  int          checks = 0, errors = 0;
  logic [31:0] exp_pc = 32'd0, exp_ret = 32'd0;

  typedef struct {
    logic [31:0] instr;
    int          idly;
    int          ddly;
    logic [4:0]  pre_reg;
    logic [31:0] pre_val;
    logic [31:0] drdata;
    logic [31:0] daddr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] npc;
  } vec_t;

  vec_t vt [12];

  always #5 clk = ~clk;

  kgp_exec_controller #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_opcode(alu_opcode), .alu_fcode(alu_fcode), .alu_shamt(alu_shamt), .alu_immt(alu_immt),
    .alu_result(alu_result),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc(pc), .busy(busy), .halted(halted), .trap(trap), .retired(retired)
  );

  // Environment: register file and a minimal ALU (fcode 1 = subtract, else add).
  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];

  always_comb begin
    alu_result = 32'd0;
    case (alu_opcode)
      3'd0:    alu_result = (alu_fcode == 4'd1) ? rs_data - rt_data : rs_data + rt_data;
      3'd1:    alu_result = rs_data + {{10{alu_immt[21]}}, alu_immt};
      default: alu_result = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (rf_we === 1'b1) regs[rf_waddr] <= rf_wdata;
    else if (tb_wr)     regs[tb_idx]   <= tb_val;
  end

  function automatic logic [31:0] enc_r(input logic [2:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [3:0] f);
    return {op, rs, rt, 5'd0, 10'd0, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [2:0] op, input logic [4:0] rs,
                                        input logic [21:0] im);
    return {op, rs, 2'b00, im};
  endfunction

  function automatic vec_t mkv(input logic [31:0] instr, input int idly, input int ddly,
                               input logic [4:0] pre_reg, input logic [31:0] pre_val,
                               input logic [31:0] drdata, input logic [31:0] daddr,
                               input logic we, input logic [4:0] waddr,
                               input logic [31:0] wdata, input logic [31:0] npc);
    vec_t v;
    v.instr = instr; v.idly = idly; v.ddly = ddly; v.pre_reg = pre_reg; v.pre_val = pre_val;
    v.drdata = drdata; v.daddr = daddr; v.we = we; v.waddr = waddr; v.wdata = wdata; v.npc = npc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input logic [4:0] idx, input logic [31:0] val);
    tb_wr = 1'b1; tb_idx = idx; tb_val = val;
    tick;
    tb_wr = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    exp_pc = 32'd0; exp_ret = 32'd0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Entered at the start of a cycle; leaves at the start of the DECODE cycle.
  task automatic fetch(input logic [31:0] instr, input int dly, input logic [31:0] pc_exp);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    for (int d = 0; d <= dly; d++) begin
      imem_ack = (d == dly); imem_rdata = instr;
      #2;
      chk("fetch_addr", imem_addr, pc_exp);
      tick;
    end
    imem_ack = 1'b0; imem_rdata = 32'd0;
  endtask

  task automatic exec_vec(input vec_t v);
    logic [2:0] op;
    op = v.instr[31:29];
    if (v.pre_reg != 5'd0) set_reg(v.pre_reg, v.pre_val);
    fetch(v.instr, v.idly, exp_pc);
    #2; chk("dec_busy", {31'd0, busy}, 32'd1); chk("dec_rfwe", {31'd0, rf_we}, 32'd0);
    tick;
    #2; chk("exec_rfwe", {31'd0, rf_we}, 32'd0);
    tick;
    if (op == 3'd2 || op == 3'd3) begin
      for (int d = 0; d <= v.ddly; d++) begin
        dmem_ack = (d == v.ddly); dmem_rdata = v.drdata;
        #2;
        chk("mem_req", {31'd0, dmem_req}, 32'd1);
        chk("mem_addr", dmem_addr, v.daddr);
        chk("mem_we", {31'd0, dmem_we}, {31'd0, (op == 3'd3)});
        if (op == 3'd3) chk("mem_wdata", dmem_wdata, v.wdata);
        tick;
      end
      dmem_ack = 1'b0; dmem_rdata = 32'd0;
    end
    #2; chk("wb_rfwe", {31'd0, rf_we}, {31'd0, v.we});
    if (v.we) begin
      chk("wb_waddr", {27'd0, rf_waddr}, {27'd0, v.waddr});
      chk("wb_wdata", rf_wdata, v.wdata);
    end
    tick;
    exp_ret = exp_ret + 32'd1;
    exp_pc  = v.npc;
    chk("next_pc", pc, exp_pc);
    chk("retired", retired, exp_ret);
  endtask

  task automatic run_halt;
    fetch(32'hE000_0000, 0, exp_pc);
    tick;
    #2;
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_busy", {31'd0, busy}, 32'd0);
    chk("halt_retired", retired, exp_ret);
    chk("halt_pc", pc, exp_pc);
    start = 1'b1;
    tick;
    tick;
    start = 1'b0;
    #2;
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    chk("halt_noreq", {31'd0, imem_req}, 32'd0);
    chk("halt_pc_hold", pc, exp_pc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = mkv(enc_r(3'd0, 5'd1, 5'd2, 4'd0),     0, 0, 5'd0, 0, 0, 0, 1'b1, 5'd1, 32'd12, 32'h4);
    vt[1]  = mkv(32'h433F_FFFC,                     1, 3, 5'd0, 0, 32'hCAFE_F00D, 32'hFC,
                 1'b1, 5'd7, 32'hCAFE_F00D, 32'h8);
    vt[2]  = mkv(enc_i(3'd3, 5'd3, 22'h080008),     0, 0, 5'd0, 0, 0, 32'h0008_0108,
                 1'b0, 5'd0, 32'd12, 32'hC);
    vt[3]  = mkv(enc_i(3'd1, 5'd2, 22'h000010),     2, 0, 5'd0, 0, 0, 0, 1'b1, 5'd2, 32'd23, 32'h10);
    vt[4]  = mkv(enc_i(3'd5, 5'd8, 22'h0),          0, 0, 5'd0, 0, 0, 0, 1'b0, 5'd0, 0, 32'h20);
    vt[5]  = mkv(enc_i(3'd4, 5'd9, 22'h000011),     0, 0, 5'd0, 0, 0, 0, 1'b0, 5'd0, 0, 32'h68);
    vt[6]  = mkv(enc_i(3'd5, 5'd8, 22'h0),          0, 0, 5'd0, 0, 0, 0, 1'b0, 5'd0, 0, 32'h20);
    vt[7]  = mkv(enc_i(3'd4, 5'd9, 22'h000011),     0, 0, 5'd9, 32'd1, 0, 0, 1'b0, 5'd0, 0, 32'h24);
    vt[8]  = mkv(enc_i(3'd4, 5'd10, 22'h000003),    0, 0, 5'd0, 0, 0, 0, 1'b0, 5'd0, 0, 32'h34);
    vt[9]  = mkv(enc_i(3'd4, 5'd9, 22'h3FFFF0),     0, 0, 5'd0, 0, 0, 0, 1'b0, 5'd0, 0, 32'hFFFF_FFF8);
    vt[10] = mkv(enc_r(3'd0, 5'd2, 5'd1, 4'd1),     0, 0, 5'd0, 0, 0, 0, 1'b1, 5'd2, 32'd11, 32'hFFFF_FFFC);
    vt[11] = mkv(enc_i(3'd1, 5'd1, 22'h000001),     0, 0, 5'd0, 0, 0, 0, 1'b1, 5'd1, 32'd13, 32'h0);

    do_reset;
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted_trap", {30'd0, halted, trap}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_reqs", {29'd0, imem_req, dmem_req, rf_we}, 32'd0);
    chk("rst_alu_opcode", {29'd0, alu_opcode}, 32'd2);
    chk("rst_fields", {alu_fcode, alu_shamt, rs_addr, rt_addr}, 32'd0);
    chk("rst_immt", {10'd0, alu_immt}, 32'd0);
    set_reg(5'd1, 32'd5);
    set_reg(5'd2, 32'd7);
    set_reg(5'd3, 32'h100);
    set_reg(5'd8, 32'h21);
    set_reg(5'd10, 32'h8000_0000);

    // Main program: ALU, load, store, immediate, jumps, branches, PC wrap.
    do_start;
    for (int i = 0; i < 12; i++) exec_vec(vt[i]);
    chk("reg_load_r7", regs[7], 32'hCAFE_F00D);
    run_halt;

    // Illegal opcode at pc=8 traps without write-back.
    do_reset;
    do_start;
    exec_vec(mkv(32'h0300_0000, 0, 0, 5'd0, 0, 0, 0, 1'b1, 5'd3, 32'h100, 32'h4));
    exec_vec(mkv(32'h0300_0000, 0, 0, 5'd0, 0, 0, 0, 1'b1, 5'd3, 32'h100, 32'h8));
    fetch(32'hC100_0000, 0, 32'h8);
    #2; chk("trap_dec_rfwe", {31'd0, rf_we}, 32'd0);
    tick;
    #2;
    chk("trap_flag", {31'd0, trap}, 32'd1);
    chk("trap_busy", {31'd0, busy}, 32'd0);
    chk("trap_rfwe", {31'd0, rf_we}, 32'd0);
    chk("trap_pc", pc, 32'h8);
    start = 1'b1;
    tick;
    tick;
    start = 1'b0;
    #2;
    chk("trap_sticky", {31'd0, trap}, 32'd1);
    chk("trap_noreq", {31'd0, imem_req}, 32'd0);
    chk("trap_pc_hold", pc, 32'h8);
    chk("trap_retired", retired, 32'd2);

    // Asynchronous reset while a store is waiting on dmem_ack.
    do_reset;
    do_start;
    fetch(enc_i(3'd3, 5'd3, 22'h080008), 0, 32'h0);
    tick;
    tick;
    #2;
    chk("st_req_before_rst", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_drop_req", {30'd0, dmem_req, dmem_we}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_pc", pc, 32'h0);
    tick;
    rst_n = 1'b1;
    dmem_ack = 1'b1; imem_ack = 1'b1;
    tick;
    dmem_ack = 1'b0; imem_ack = 1'b0;
    #2;
    chk("late_ack_busy", {31'd0, busy}, 32'd0);
    chk("late_ack_reqs", {29'd0, imem_req, dmem_req, rf_we}, 32'd0);
    chk("late_ack_pc", pc, 32'h0);
    chk("late_ack_retired", retired, 32'd0);

    // Halt after exactly three retired instructions.
    tick;
    do_start;
    for (int i = 0; i < 3; i++)
      exec_vec(mkv(32'h0300_0000, 0, 0, 5'd0, 0, 0, 0, 1'b1, 5'd3, 32'h100, 32'(4 * (i + 1))));
    run_halt;
    chk("halt3_retired", retired, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
